// File: rtl/rxframe.sv
// rtl/rxframe.sv - receive frame checker feeding a show-ahead byte FIFO
//
// Purpose:
//   Sits after the rx shift register. Each completed 11-bit frame has its
//   start, parity and stop bits checked. The data byte and its error tags are
//   then pushed into a show-ahead FIFO. The host side drains the FIFO with a
//   valid/ready handshake.
//
// Configuration macro:
//   RXFRAME_DROP_BAD_EN - when defined, frames with a parity or framing error
//   are discarded. With this macro the FIFO holds only the data byte, and the
//   error tag outputs are tied to 0. When undefined, every frame is stored
//   together with its tags.
//
// Ports:
//   i_Pclk         clock, all logic on the rising edge
//   i_Rst          asynchronous active-high reset
//   i_Frame_Valid  1-cycle pulse, i_Frame holds a complete frame
//   i_Frame        [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
//   o_Rx_Data      data byte at the FIFO head
//   o_Rx_Perr      parity-error tag of the head entry
//   o_Rx_Ferr      framing-error tag of the head entry
//   o_Rx_Valid     FIFO not empty, head entry valid
//   i_Rx_Ready     consumer takes the head when o_Rx_Valid & i_Rx_Ready
//   o_Count        entries currently stored (0..DEPTH)
//   o_Overrun      sticky flag, a frame arrived while the FIFO was full
//   i_Err_Clr      1-cycle pulse that clears o_Overrun

module rxframe #(
  parameter int ADDR_W     = 3,
  parameter int PARITY_ODD = 0
) (
  input  logic              i_Pclk,
  input  logic              i_Rst,
  input  logic              i_Frame_Valid,
  input  logic [10:0]       i_Frame,
  output logic [7:0]        o_Rx_Data,
  output logic              o_Rx_Perr,
  output logic              o_Rx_Ferr,
  output logic              o_Rx_Valid,
  input  logic              i_Rx_Ready,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overrun,
  input  logic              i_Err_Clr
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RXFRAME_DROP_BAD_EN
  localparam int ENTRY_W = 8;
`else
  localparam int ENTRY_W = 10;
`endif
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count;
  logic               overrun;

  logic               perr;
  logic               ferr;
  logic               full;
  logic               empty;
  logic               pop;
  logic               accept;
  logic               wr_en;
  logic               ovf_evt;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;

  // Frame checks look only at the current i_Frame.
  // Parity covers the data bits and the parity bit together.
  always_comb begin
    perr = ((^i_Frame[9:1]) != PAR_ODD);
    ferr = i_Frame[0] | ~i_Frame[10];
  end

  // Count can only reach DEPTH = 2**ADDR_W, so its top bit alone means full.
  always_comb begin
    full  = count[ADDR_W];
    empty = (count == '0);
    pop   = ~empty & i_Rx_Ready;
  end

`ifdef RXFRAME_DROP_BAD_EN
  always_comb begin
    accept   = i_Frame_Valid & ~(perr | ferr);
    wr_entry = i_Frame[8:1];
  end
`else
  always_comb begin
    accept   = i_Frame_Valid;
    wr_entry = {ferr, perr, i_Frame[8:1]};
  end
`endif

  // When full, a pop in the same cycle frees the head slot. wr_ptr equals
  // rd_ptr in that case, so the new entry lands in the slot just consumed.
  always_comb begin
    wr_en   = accept & (~full | pop);
    ovf_evt = accept & full & ~pop;
  end

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A new overrun event takes priority over a clear in the same cycle.
  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      overrun <= 1'b0;
    end else if (ovf_evt) begin
      overrun <= 1'b1;
    end else if (i_Err_Clr) begin
      overrun <= 1'b0;
    end
  end

  // Show-ahead: the head entry is read straight from storage, so it is
  // visible in the same cycle that o_Rx_Valid goes high.
  always_comb begin
    head       = mem[rd_ptr];
    o_Rx_Data  = head[7:0];
    o_Rx_Valid = ~empty;
    o_Count    = count;
    o_Overrun  = overrun;
  end

`ifdef RXFRAME_DROP_BAD_EN
  always_comb begin
    o_Rx_Perr = 1'b0;
    o_Rx_Ferr = 1'b0;
  end
`else
  always_comb begin
    o_Rx_Perr = head[8];
    o_Rx_Ferr = head[9];
  end
`endif

endmodule

// File: tb/tb_rxframe.sv
// tb/tb_rxframe.sv - directed self-checking bench for rxframe (default build)

module tb_rxframe;

  logic        i_Pclk;
  logic        i_Rst;
  logic        i_Frame_Valid;
  logic [10:0] i_Frame;
  logic [7:0]  o_Rx_Data;
  logic        o_Rx_Perr;
  logic        o_Rx_Ferr;
  logic        o_Rx_Valid;
  logic        i_Rx_Ready;
  logic [3:0]  o_Count;
  logic        o_Overrun;
  logic        i_Err_Clr;

  int checks = 0;
  int errors = 0;

  rxframe #(.ADDR_W(3), .PARITY_ODD(0)) dut (
    .i_Pclk        (i_Pclk),
    .i_Rst         (i_Rst),
    .i_Frame_Valid (i_Frame_Valid),
    .i_Frame       (i_Frame),
    .o_Rx_Data     (o_Rx_Data),
    .o_Rx_Perr     (o_Rx_Perr),
    .o_Rx_Ferr     (o_Rx_Ferr),
    .o_Rx_Valid    (o_Rx_Valid),
    .i_Rx_Ready    (i_Rx_Ready),
    .o_Count       (o_Count),
    .o_Overrun     (o_Overrun),
    .i_Err_Clr     (i_Err_Clr)
  );

  initial i_Pclk = 1'b0;
  always #5 i_Pclk = ~i_Pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge i_Pclk);
    #1;
  endtask

  // Build a frame {stop, parity, data, start}. A good parity bit for even
  // parity is ^data.
  function automatic logic [10:0] mkframe(input logic [7:0] d, input logic par,
                                          input logic start, input logic stop);
    return {stop, par, d, start};
  endfunction

  function automatic logic [10:0] good(input logic [7:0] d);
    return mkframe(d, ^d, 1'b0, 1'b1);
  endfunction

  task automatic push(input logic [10:0] f);
    i_Frame_Valid = 1'b1;
    i_Frame       = f;
    step();
    i_Frame_Valid = 1'b0;
    i_Frame       = '0;
  endtask

  initial begin
    i_Rst         = 1'b1;
    i_Frame_Valid = 1'b0;
    i_Frame       = '0;
    i_Rx_Ready    = 1'b0;
    i_Err_Clr     = 1'b0;
    #1;
    check("rst_valid", o_Rx_Valid, 0);
    check("rst_count", o_Count, 0);
    check("rst_ovr",   o_Overrun, 0);
    check("rst_data",  o_Rx_Data, 0);
    check("rst_tags",  {o_Rx_Ferr, o_Rx_Perr}, 0);
    step();
    step();
    i_Rst = 1'b0;
    step();

    // Good frame carrying 0x55, then pop it.
    push(11'b1_0_01010101_0);
    check("t1_valid", o_Rx_Valid, 1);
    check("t1_data",  o_Rx_Data, 8'h55);
    check("t1_perr",  o_Rx_Perr, 0);
    check("t1_ferr",  o_Rx_Ferr, 0);
    check("t1_count", o_Count, 1);
    i_Rx_Ready = 1'b1;
    step();
    i_Rx_Ready = 1'b0;
    check("t1_empty", o_Rx_Valid, 0);
    check("t1_count0", o_Count, 0);

    // Parity error: data 0x01 with parity bit 0.
    push(mkframe(8'h01, 1'b0, 1'b0, 1'b1));
    check("t2_valid", o_Rx_Valid, 1);
    check("t2_perr",  o_Rx_Perr, 1);
    check("t2_ferr",  o_Rx_Ferr, 0);
    check("t2_data",  o_Rx_Data, 8'h01);
    i_Rx_Ready = 1'b1;
    step();
    i_Rx_Ready = 1'b0;

    // Framing error: stop bit 0, data 0xA3 (parity bit correct).
    push(mkframe(8'hA3, 1'b0, 1'b0, 1'b0));
    check("t3_ferr", o_Rx_Ferr, 1);
    check("t3_perr", o_Rx_Perr, 0);
    check("t3_data", o_Rx_Data, 8'hA3);
    i_Rx_Ready = 1'b1;
    step();
    i_Rx_Ready = 1'b0;
    check("t3_count0", o_Count, 0);

    // Ready while empty has no effect.
    i_Rx_Ready = 1'b1;
    step();
    check("underflow_count", o_Count, 0);
    check("underflow_valid", o_Rx_Valid, 0);
    // Empty + frame + ready in the same cycle: write only.
    push(good(8'h3C));
    check("emp_wr_count", o_Count, 1);
    check("emp_wr_data",  o_Rx_Data, 8'h3C);
    step();
    i_Rx_Ready = 1'b0;
    check("emp_wr_pop", o_Count, 0);

    // Fill 8 back-to-back, overflow with a 9th frame, then drain in order.
    i_Frame_Valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_Frame = good(8'(i));
      step();
    end
    i_Frame_Valid = 1'b0;
    check("t4_count8", o_Count, 8);
    check("t4_hold",   o_Rx_Data, 8'h00);
    push(good(8'h08));
    check("t4_ovr",     o_Overrun, 1);
    check("t4_count8b", o_Count, 8);
    check("t4_head",    o_Rx_Data, 8'h00);
    i_Rx_Ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_drain%0d", i), o_Rx_Data, 32'(i));
      step();
    end
    i_Rx_Ready = 1'b0;
    check("t4_empty",   o_Rx_Valid, 0);
    check("t4_ovr_sticky", o_Overrun, 1);
    i_Err_Clr = 1'b1;
    step();
    i_Err_Clr = 1'b0;
    check("t4_clr", o_Overrun, 0);

    // Full + frame + pop in the same cycle: both happen, no overrun.
    i_Frame_Valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_Frame = good(8'(8'h10 + i));
      step();
    end
    i_Frame = good(8'h99);
    i_Rx_Ready = 1'b1;
    step();
    i_Frame_Valid = 1'b0;
    i_Rx_Ready = 1'b0;
    check("t5_count", o_Count, 8);
    check("t5_ovr",   o_Overrun, 0);
    check("t5_head",  o_Rx_Data, 8'h11);

    // Overrun and clear in the same cycle: overrun wins.
    i_Err_Clr = 1'b1;
    push(good(8'h77));
    i_Err_Clr = 1'b0;
    check("clr_vs_ovr", o_Overrun, 1);
    i_Rx_Ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check($sformatf("t5_drain%0d", i), o_Rx_Data, 32'(8'h10 + i));
      step();
    end
    check("t5_last", o_Rx_Data, 8'h99);
    step();
    i_Rx_Ready = 1'b0;
    check("t5_empty", o_Count, 0);

    // Async reset with 3 entries stored.
    push(good(8'hA1));
    push(good(8'hA2));
    push(good(8'hA3));
    check("t6_pre", o_Count, 3);
    #2;
    i_Rst = 1'b1;
    #1;
    check("t6_valid", o_Rx_Valid, 0);
    check("t6_count", o_Count, 0);
    check("t6_ovr",   o_Overrun, 0);
    step();
    i_Rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
